// File: rtl/app_spi_ctrl.sv
// app_spi_ctrl: OPB-mapped SPI master (mode 0, MSB first) driving two
// targets that share one SCLK and have separate CS_N/MOSI/MISO.
//
// Optional feature macro: APP_SPI_IRQ_EN adds CTRL.IEN (bit2) and a
// registered SPI_IRQ = DONE & IEN output.
//
// Ports:
//   OPB_CLK, OPB_RST        clock, async active-high reset
//   OPB_DI / OPB_DO         write data / registered read data
//   OPB_ADDR[3:2]           register select (CTRL, TXDATA, RXDATA, STATUS)
//   APP_RE / APP_WE         single-cycle read / write strobes
//   APP_FPGA_SPI_CLK        shared SCLK
//   APP_FPGA_SPIn_CS_N      active-low target selects
//   APP_FPGA_SPIn_MOSI/MISO serial data out / in
//   SPI_IRQ                 (APP_SPI_IRQ_EN only) transfer-done interrupt
module app_spi_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] OPB_DI,
  output logic [31:0] OPB_DO,
  input  logic [31:0] OPB_ADDR,
  input  logic        APP_RE,
  input  logic        APP_WE,
  output logic        APP_FPGA_SPI_CLK,
  output logic        APP_FPGA_SPI0_CS_N,
  output logic        APP_FPGA_SPI1_CS_N,
  output logic        APP_FPGA_SPI0_MOSI,
  output logic        APP_FPGA_SPI1_MOSI,
  input  logic        APP_FPGA_SPI0_MISO,
  input  logic        APP_FPGA_SPI1_MISO
`ifdef APP_SPI_IRQ_EN
  ,
  output logic        SPI_IRQ
`endif
);

  localparam int unsigned BUS_W = 32;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned DIV_W = 8;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_TX   = 2'd1;
  localparam logic [1:0] A_RX   = 2'd2;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                  state_q, state_nx;
  logic [DIV_W-1:0]        div_cnt_q;
  logic [LEN_W-1:0]        bit_cnt_q;
  logic                    tgt_q;
  logic [LEN_W-1:0]        len_q;
  logic [DATA_WIDTH-1:0]   txdata_q, rxdata_q, tx_sh_q, tx_sh_nx, rx_sh_q;
  logic                    done_q, err_q;
  logic                    sclk_q, cs0_n_q, cs1_n_q, mosi0_q, mosi1_q;
  logic [BUS_W-1:0]        do_q;
  logic                    ien_rd_c;

  logic [1:0]              sel_c;
  logic                    busy_c, wr_ctrl_c, wr_tx_c, wr_stat_c, rd_rx_c;
  logic                    start_c, tick_c, rise_c, fall_c, last_c, finish_c;
  logic                    miso_c, tgt_nx_c, active_nx_c, mosi_nx_c;
  logic [DIV_W-1:0]        shamt_c;
  logic [BUS_W-1:0]        rd_data_c;
  logic                    unused_c;

  // Bus decode and engine strobes
  assign sel_c     = OPB_ADDR[3:2];
  assign busy_c    = (state_q != IDLE);
  assign wr_ctrl_c = APP_WE && (sel_c == A_CTRL);
  assign wr_tx_c   = APP_WE && (sel_c == A_TX);
  assign wr_stat_c = APP_WE && (sel_c == 2'd3);
  assign rd_rx_c   = APP_RE && (sel_c == A_RX);
  assign start_c   = wr_ctrl_c && !busy_c && OPB_DI[0];
  assign tick_c    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign rise_c    = (state_q == SHIFT) && tick_c && !sclk_q;
  assign fall_c    = (state_q == SHIFT) && tick_c && sclk_q;
  assign last_c    = (bit_cnt_q == '0);
  assign finish_c  = (state_q == HOLD) && tick_c;
  assign miso_c    = tgt_q ? APP_FPGA_SPI1_MISO : APP_FPGA_SPI0_MISO;
  assign unused_c  = ^{OPB_ADDR[31:4], OPB_ADDR[1:0], OPB_DI};

  // Left-justify the LEN+1 payload bits so the current bit is always the MSB
  assign shamt_c = DIV_W'(DATA_WIDTH - 1) - DIV_W'(OPB_DI[12:8]);

  // State register
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) state_q <= IDLE;
    else         state_q <= state_nx;
  end

  // Next state and transmit shifter
  always_comb begin
    state_nx = state_q;
    tx_sh_nx = tx_sh_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_nx = SETUP;
          tx_sh_nx = txdata_q << shamt_c;
        end
      end
      SETUP: begin
        if (tick_c) state_nx = SHIFT;
      end
      SHIFT: begin
        if (fall_c) begin
          if (last_c) state_nx = HOLD;
          else        tx_sh_nx = tx_sh_q << 1;
        end
      end
      HOLD: begin
        if (tick_c) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin values for the upcoming cycle; target comes from the START write
  assign tgt_nx_c    = start_c ? OPB_DI[1] : tgt_q;
  assign active_nx_c = (state_nx != IDLE);
  assign mosi_nx_c   = ((state_nx == SETUP) || (state_nx == SHIFT)) &&
                       tx_sh_nx[DATA_WIDTH-1];

  // Shift engine and SPI pins
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      sclk_q    <= 1'b0;
      cs0_n_q   <= 1'b1;
      cs1_n_q   <= 1'b1;
      mosi0_q   <= 1'b0;
      mosi1_q   <= 1'b0;
    end else begin
      if (!busy_c || tick_c) div_cnt_q <= '0;
      else                   div_cnt_q <= div_cnt_q + DIV_W'(1);

      if (start_c)                bit_cnt_q <= OPB_DI[12:8];
      else if (fall_c && !last_c) bit_cnt_q <= bit_cnt_q - LEN_W'(1);

      tx_sh_q <= tx_sh_nx;

      if (start_c)     rx_sh_q <= '0;
      else if (rise_c) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso_c};

      if ((state_q == SHIFT) && tick_c) sclk_q <= ~sclk_q;

      cs0_n_q <= !(active_nx_c && !tgt_nx_c);
      cs1_n_q <= !(active_nx_c && tgt_nx_c);
      mosi0_q <= mosi_nx_c && !tgt_nx_c;
      mosi1_q <= mosi_nx_c && tgt_nx_c;
    end
  end

  // Programmer-visible registers; CTRL/TXDATA are frozen while busy
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      tgt_q    <= 1'b0;
      len_q    <= '0;
      txdata_q <= '0;
      rxdata_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_ctrl_c && !busy_c) begin
        tgt_q <= OPB_DI[1];
        len_q <= OPB_DI[12:8];
      end
      if (wr_tx_c && !busy_c) txdata_q <= OPB_DI[DATA_WIDTH-1:0];
      if (finish_c) rxdata_q <= rx_sh_q;

      // Completion wins over a coincident clear
      if (finish_c)                done_q <= 1'b1;
      else if (rd_rx_c || start_c) done_q <= 1'b0;

      if ((wr_ctrl_c || wr_tx_c) && busy_c) err_q <= 1'b1;
      else if (wr_stat_c && OPB_DI[2])      err_q <= 1'b0;
    end
  end

`ifdef APP_SPI_IRQ_EN
  logic ien_q, irq_q;

  // Interrupt enable and registered interrupt
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl_c && !busy_c) ien_q <= OPB_DI[2];
      irq_q <= done_q && ien_q;
    end
  end

  assign ien_rd_c = ien_q;
  assign SPI_IRQ  = irq_q;
`else
  assign ien_rd_c = 1'b0;
`endif

  // Read mux
  always_comb begin
    rd_data_c = '0;
    case (sel_c)
      A_CTRL:  rd_data_c = {19'd0, len_q, 5'd0, ien_rd_c, tgt_q, 1'b0};
      A_TX:    rd_data_c = BUS_W'(txdata_q);
      A_RX:    rd_data_c = BUS_W'(rxdata_q);
      default: rd_data_c = {29'd0, err_q, done_q, busy_c};
    endcase
  end

  // Read data register, held between reads
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST)     do_q <= '0;
    else if (APP_RE) do_q <= rd_data_c;
  end

  assign OPB_DO             = do_q;
  assign APP_FPGA_SPI_CLK   = sclk_q;
  assign APP_FPGA_SPI0_CS_N = cs0_n_q;
  assign APP_FPGA_SPI1_CS_N = cs1_n_q;
  assign APP_FPGA_SPI0_MOSI = mosi0_q;
  assign APP_FPGA_SPI1_MOSI = mosi1_q;

endmodule

// File: tb/tb_app_spi_ctrl.sv
// tb_app_spi_ctrl: randomized self-checking bench for app_spi_ctrl.
// Expected transfer results come from the register rules: MOSI carries
// TXDATA[LEN:0] MSB first, RXDATA is the MISO bits seen at SCLK rises,
// right-aligned, and a transfer keeps CS_N low CLK_DIV*(2*(LEN+1)+2) cycles.
module tb_app_spi_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DW      = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] di, do_w, addr;
  logic        re, we;
  logic        sclk, cs0, cs1, mosi0, mosi1, miso0, miso1;
  logic        irq;

  int          total = 0;
  int          bad   = 0;

  int          miso_mode;
  logic        rnd_bit = 1'b0;
  logic        exp_err;
  logic [31:0] last_rx;

  int          cyc = 0;
  int          nrise, last_rise, bad_tim, bad_idle, cs_low;
  logic [31:0] mosi_bits, miso_bits;
  logic        mon_tgt;

  always #5 clk = ~clk;

  app_spi_ctrl #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
    .OPB_CLK            (clk),
    .OPB_RST            (rst),
    .OPB_DI             (di),
    .OPB_DO             (do_w),
    .OPB_ADDR           (addr),
    .APP_RE             (re),
    .APP_WE             (we),
    .APP_FPGA_SPI_CLK   (sclk),
    .APP_FPGA_SPI0_CS_N (cs0),
    .APP_FPGA_SPI1_CS_N (cs1),
    .APP_FPGA_SPI0_MOSI (mosi0),
    .APP_FPGA_SPI1_MOSI (mosi1),
    .APP_FPGA_SPI0_MISO (miso0),
    .APP_FPGA_SPI1_MISO (miso1)
`ifdef APP_SPI_IRQ_EN
    ,
    .SPI_IRQ            (irq)
`endif
  );

`ifndef APP_SPI_IRQ_EN
  assign irq = 1'b0;
`endif

  // MISO stimulus: 0 = loopback of own MOSI, 1 = held high, 2 = random
  assign miso0 = (miso_mode == 0) ? mosi0 : (miso_mode == 1) ? 1'b1 : rnd_bit;
  assign miso1 = (miso_mode == 0) ? mosi1 : (miso_mode == 1) ? 1'b1 : rnd_bit;

  always @(negedge clk) rnd_bit = 1'($urandom);
  always @(posedge clk) cyc = cyc + 1;

  // Record bits at each SCLK rise and check the SCLK period
  always @(posedge sclk) begin
    mosi_bits = {mosi_bits[30:0], mon_tgt ? mosi1 : mosi0};
    miso_bits = {miso_bits[30:0], mon_tgt ? miso1 : miso0};
    if (nrise > 0 && (cyc - last_rise) != 2 * CLK_DIV) bad_tim = bad_tim + 1;
    if ((mon_tgt ? cs1 : cs0) != 1'b0) bad_tim = bad_tim + 1;
    last_rise = cyc;
    nrise = nrise + 1;
  end

  always @(negedge sclk) begin
    if (!rst && (cyc - last_rise) != CLK_DIV) bad_tim = bad_tim + 1;
  end

  // Unselected target must stay idle; count selected-CS low cycles
  always @(negedge clk) begin
    if (mon_tgt) begin
      if (cs0 !== 1'b1 || mosi0 !== 1'b0) bad_idle = bad_idle + 1;
      if (cs1 === 1'b0) cs_low = cs_low + 1;
    end else begin
      if (cs1 !== 1'b1 || mosi1 !== 1'b0) bad_idle = bad_idle + 1;
      if (cs0 === 1'b0) cs_low = cs_low + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    nrise = 0; last_rise = 0; bad_tim = 0; bad_idle = 0; cs_low = 0;
    mosi_bits = '0; miso_bits = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = {28'd0, a, 2'd0}; di = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = {28'd0, a, 2'd0}; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = do_w;
  endtask

  function automatic logic [31:0] len_mask(input logic [4:0] len);
    if (len == 5'd31) return 32'hFFFF_FFFF;
    return (32'd1 << (32'(len) + 32'd1)) - 32'd1;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic tgt, input logic [4:0] len, input logic start);
    return (32'(len) << 8) | (32'(tgt) << 1) | 32'(start);
  endfunction

  // One complete transfer with all protocol and register checks
  task automatic run_xfer(input logic tgt, input logic [4:0] len, input logic [31:0] tx,
                          input int mode, input bit poke);
    logic [31:0] mask, exp_rx, st, d;
    logic [4:0]  plen;
    logic        ptgt;
    bit          seen;
    mask = len_mask(len);
    miso_mode = mode;
    wr(2'd1, tx);
    mon_clear();
    mon_tgt = tgt;
    wr(2'd0, ctrl_word(tgt, len, 1'b1));
    rd(2'd3, st);
    chk("busy", 32'(st[0]), 32'd1);
    if (poke) begin
      plen = ~len;
      ptgt = ~tgt;
      wr(2'd0, ctrl_word(ptgt, plen, 1'b1));
      wr(2'd1, ~tx);
      exp_err = 1'b1;
    end
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      rd(2'd3, st);
      seen = st[1];
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("pulses", 32'(nrise), 32'(len) + 32'd1);
    chk("mosi_bits", mosi_bits & mask, tx & mask);
    chk("sclk_timing", 32'(bad_tim), 32'd0);
    chk("idle_pins", 32'(bad_idle), 32'd0);
    chk("cs_low_cycles", 32'(cs_low), 32'(CLK_DIV * (2 * (int'(len) + 1) + 2)));
    exp_rx = (mode == 0) ? (tx & mask) : (mode == 1) ? mask : (miso_bits & mask);
    chk("status_done", st, {29'd0, exp_err, 2'b10});
    if (poke) begin
      wr(2'd3, 32'h4);
      exp_err = 1'b0;
      rd(2'd3, st);
      chk("err_clear", st, 32'h2);
    end
    rd(2'd2, d);
    chk("rxdata", d, exp_rx);
    last_rx = exp_rx;
    rd(2'd3, st);
    chk("done_cleared", st, {29'd0, exp_err, 2'b00});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, st, tx;
    logic [4:0]  len;
    int          n;
    bit          found;

    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; di = '0;
    miso_mode = 0; mon_tgt = 1'b0; exp_err = 1'b0; last_rx = '0;
    mon_clear();
    repeat (3) @(negedge clk);
    chk("reset_pins", 32'({cs1, cs0, sclk, mosi1, mosi0}), 32'h18);
    chk("reset_do", do_w, 32'd0);
    rst = 1'b0;
    rd(2'd3, d); chk("reset_status", d, 32'd0);
    rd(2'd2, d); chk("reset_rxdata", d, 32'd0);
    rd(2'd0, d); chk("reset_ctrl", d, 32'd0);

    // CTRL readback without START; IEN only exists with the IRQ option
    wr(2'd0, 32'h0000_0C07 & ~32'h1);
`ifdef APP_SPI_IRQ_EN
    rd(2'd0, d); chk("ctrl_rb", d, 32'h0000_0C06);
`else
    rd(2'd0, d); chk("ctrl_rb", d, 32'h0000_0C02);
`endif
    rd(2'd3, d); chk("no_start", d, 32'd0);

    run_xfer(1'b0, 5'd7, 32'h0000_00A5, 0, 0);
    run_xfer(1'b1, 5'd31, 32'hDEAD_BEEF, 1, 0);
    run_xfer(1'b1, 5'd0, 32'hFFFF_FFFE, 0, 0);
    run_xfer(1'b0, 5'd11, $urandom, 2, 1);
    for (int k = 0; k < 8; k++)
      run_xfer(1'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 2)), 0);

    // Simultaneous read and write: read returns pre-write contents
    wr(2'd1, 32'h1234_5678);
    @(negedge clk);
    addr = 32'h4; di = 32'hCAFE_F00D; re = 1'b1; we = 1'b1;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    chk("rw_old", do_w, 32'h1234_5678);
    repeat (3) @(negedge clk);
    chk("do_hold", do_w, 32'h1234_5678);
    rd(2'd1, d); chk("rw_new", d, 32'hCAFE_F00D);

    // RXDATA read landing on the DONE-set cycle leaves DONE at 1
    tx = $urandom; len = 5'd3;
    miso_mode = 0; mon_tgt = 1'b0;
    wr(2'd1, tx);
    mon_clear();
    wr(2'd0, ctrl_word(1'b0, len, 1'b1));
    n = CLK_DIV * (2 * (int'(len) + 1) + 2);
    repeat (n - 1) @(negedge clk);
    addr = 32'h8; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("rd_at_done_old", do_w, last_rx);
    rd(2'd3, st); chk("done_kept", st, 32'h2);
    rd(2'd2, d); chk("rx_after_race", d, tx & len_mask(len));
    last_rx = tx & len_mask(len);
    rd(2'd3, st); chk("done_clr_race", st, 32'd0);

`ifdef APP_SPI_IRQ_EN
    // 1-bit transfer with IEN: IRQ follows DONE by one cycle each way
    miso_mode = 1; mon_tgt = 1'b0;
    wr(2'd1, 32'h1);
    mon_clear();
    wr(2'd0, 32'h0000_0005);
    n = CLK_DIV * 4;
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      chk("irq_rise", 32'(irq), 32'(i > n));
    end
    rd(2'd2, d);
    chk("irq_rx", d, 32'h1);
    chk("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_fall", 32'(irq), 32'd0);
`endif

    // Reset at the third SCLK rising edge
    miso_mode = 2; mon_tgt = 1'b0;
    wr(2'd1, $urandom);
    mon_clear();
    wr(2'd0, ctrl_word(1'b0, 5'd15, 1'b1));
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (nrise == 3) begin
        found = 1;
        break;
      end
    end
    chk("rise3_seen", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_pins", 32'({cs1, cs0, sclk, mosi1, mosi0}), 32'h18);
    chk("rst_do", do_w, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(2'd3, d); chk("rst_status", d, 32'd0);
    rd(2'd2, d); chk("rst_rxdata", d, 32'd0);
    repeat (2 * CLK_DIV * 20) @(negedge clk);
    chk("rst_no_pulses", 32'(nrise), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/app_spi_ctrl.md
APP_SPI_CTRL -- requirements
Module: app_spi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in OPB_CLK cycles, legal range 2..255.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the TXDATA and RXDATA registers.
REQ-003 SHALL have port OPB_CLK, input, 1: clock.
REQ-004 SHALL have port OPB_RST, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port OPB_DI, input, 32: write data.
REQ-006 SHALL have port OPB_DO, output, 32: registered read data.
REQ-007 SHALL have port OPB_ADDR, input, 32: register select via bits [3:2].
REQ-008 SHALL have port APP_RE, input, 1: single-cycle read strobe.
REQ-009 SHALL have port APP_WE, input, 1: single-cycle write strobe.
REQ-010 SHALL have port APP_FPGA_SPI_CLK, output, 1: shared SCLK.
REQ-011 SHALL have ports APP_FPGA_SPI0_CS_N and APP_FPGA_SPI1_CS_N, output, 1 each: active-low target selects.
REQ-012 SHALL have ports APP_FPGA_SPI0_MOSI and APP_FPGA_SPI1_MOSI, output, 1 each: serial data out.
REQ-013 SHALL have ports APP_FPGA_SPI0_MISO and APP_FPGA_SPI1_MISO, input, 1 each: serial data in.

Function
REQ-014 SHALL decode register map by ADDR[3:2]:
- 0: CTRL. Write bit0 = START (self-clearing), bit1 = TGT (0 = SPI0, 1 = SPI1), bits[12:8] = LEN, transfer length LEN+1 bits.
- 1: TXDATA.
- 2: RXDATA, read-only.
- 3: STATUS. bit0 BUSY, bit1 DONE, bit2 ERR.
REQ-015 SHALL drive OPB_DO one cycle after APP_RE with the addressed register, and hold the value otherwise.
REQ-016 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD:
- IDLE->SETUP on a START write.
- SETUP->SHIFT after CLK_DIV cycles.
- SHIFT->HOLD after the last bit's falling edge.
- HOLD->IDLE after CLK_DIV cycles.
REQ-017 SHALL assert the selected CS_N low from SETUP entry through HOLD exit; the unselected CS_N stays high.
REQ-018 SHALL use SPI mode 0:
- SCLK idle low and toggles every CLK_DIV cycles in SHIFT.
- MOSI is valid before each rising edge.
- MISO is sampled on the rising edge.
- Shifting is MSB first from TXDATA bit LEN.
REQ-019 SHALL drive only the selected MOSI; the unselected MOSI is held 0.
REQ-020 SHALL right-align received bits in RXDATA[LEN:0] and zero the upper bits.
REQ-021 SHALL set DONE on HOLD->IDLE, and clear DONE on a RXDATA read or a START write.
REQ-022 SHALL read BUSY as 1 in any state other than IDLE.
REQ-023 SHALL ignore CTRL and TXDATA writes while BUSY and set ERR (sticky); ERR is cleared by writing 1 to STATUS bit2.
REQ-024 SHALL give the write priority when APP_RE and APP_WE coincide; the read returns pre-write contents.
REQ-025 SHALL, when a RXDATA read coincides with the DONE set, leave DONE at 1.
REQ-026 SHALL latch TGT and LEN at START; TXDATA is snapshotted into the shift register at START.

Reset
REQ-027 SHALL, on OPB_RST, immediately and asynchronously:
- force CS_N = 1 on both selects, SCLK = 0, MOSI = 0 on both.
- force FSM to IDLE and all registers, OPB_DO included, to 0.
REQ-028 SHALL discard any mid-transfer data on reset; no DONE is set.

Configuration
REQ-029 SHALL support macro APP_SPI_IRQ_EN. When defined:
- Output port SPI_IRQ (1 bit) is added.
- CTRL bit2 = IEN is readable and writable.
- SPI_IRQ = DONE & IEN, registered.
REQ-030 SHALL, without APP_SPI_IRQ_EN, omit the SPI_IRQ port; CTRL bit2 reads 0 and writes to it are ignored.

Verification
REQ-031 Write TXDATA = 0xA5 and CTRL = 0x0701 with CLK_DIV = 4, and tie SPI0_MISO to SPI0_MOSI. Required response:
- 8 SCLK pulses, each 8 cycles long.
- SPI0_MOSI pattern 1,0,1,0,0,1,0,1.
- SPI1_CS_N stays high.
- RXDATA = 0x000000A5 and DONE = 1.
REQ-032 Run a 32-bit transfer on SPI1 with TXDATA = 0xDEADBEEF and MISO held 1. Required response: RXDATA = 0xFFFFFFFF; SPI0 pins stay idle.
REQ-033 Write CTRL while BUSY. Required response: the transfer continues unchanged, ERR = 1, and writing STATUS = 0x4 clears ERR.
REQ-034 Assert OPB_RST at the 3rd SCLK rising edge. Required response: CS_N = 1 and SCLK = 0 within the same cycle; STATUS reads 0 after release.
REQ-035 With APP_SPI_IRQ_EN defined and IEN = 1, complete a 1-bit transfer (LEN = 0). Required response:
- SPI_IRQ rises 1 cycle after DONE.
- SPI_IRQ falls 1 cycle after the RXDATA read.
